// File: rtl/exe_wb_arb_pkg.sv
// Shared execution-unit definitions for the writeback arbiter: unit encoding, widths, fixed priority order.
// The EXE_WB_RR_EN macro selects round-robin arbitration; without it the arbiter uses FIXED_ORDER.
package exe_wb_arb_pkg;

  localparam int ROB_ID_W  = 6;
  localparam int DATA_W    = 32;
  localparam int NUM_UNITS = 6;

  typedef enum logic [2:0] {
    UNIT_ALU  = 3'd0,
    UNIT_DIV  = 3'd1,
    UNIT_FPU  = 3'd2,
    UNIT_FDIV = 3'd3,
    UNIT_CSR  = 3'd4,
    UNIT_MEM  = 3'd5
  } ExeUnit_t;

  // Highest priority first; used when round-robin is not built in.
  localparam ExeUnit_t FIXED_ORDER [NUM_UNITS] =
    '{UNIT_ALU, UNIT_MEM, UNIT_CSR, UNIT_FPU, UNIT_DIV, UNIT_FDIV};

  function automatic ExeUnit_t next_unit(input ExeUnit_t u);
    return (u == UNIT_MEM) ? UNIT_ALU : ExeUnit_t'(u + 3'd1);
  endfunction

endpackage

// File: rtl/exe_wb_arb_if.sv
// Bus between the execution units, the writeback arbiter and the commit stage.
// Done/grant strobes and wb_e_ are active-low.
interface exe_wb_arb_if;
  import exe_wb_arb_pkg::*;

  logic done_alu_, done_div_, done_fpu_, done_fdiv_, done_csr_, done_mem_;
  logic [NUM_UNITS-1:0][ROB_ID_W-1:0] done_tag;
  logic [NUM_UNITS-1:0][DATA_W-1:0]   done_data;
  logic [NUM_UNITS-1:0]               done_exp;
  logic gnt_alu_, gnt_div_, gnt_fpu_, gnt_fdiv_, gnt_csr_, gnt_mem_;
  logic                wb_stall;
  logic                wb_e_;
  ExeUnit_t            wb_unit;
  logic [ROB_ID_W-1:0] wb_tag;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_exp;

  modport slave (
    input  done_alu_, done_div_, done_fpu_, done_fdiv_, done_csr_, done_mem_,
    input  done_tag, done_data, done_exp, wb_stall,
    output gnt_alu_, gnt_div_, gnt_fpu_, gnt_fdiv_, gnt_csr_, gnt_mem_,
    output wb_e_, wb_unit, wb_tag, wb_data, wb_exp
  );

  modport master (
    output done_alu_, done_div_, done_fpu_, done_fdiv_, done_csr_, done_mem_,
    output done_tag, done_data, done_exp, wb_stall,
    input  gnt_alu_, gnt_div_, gnt_fpu_, gnt_fdiv_, gnt_csr_, gnt_mem_,
    input  wb_e_, wb_unit, wb_tag, wb_data, wb_exp
  );

endinterface

// File: rtl/exe_wb_rr.sv
// Six-way picker: the first requester at or after ptr (wrapping MEM->ALU) gets a one-hot grant.
module exe_wb_rr
  import exe_wb_arb_pkg::*;
(
  input  logic [NUM_UNITS-1:0] req,
  input  ExeUnit_t             ptr,
  output logic [NUM_UNITS-1:0] gnt
);

  logic       found;
  logic [2:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      idx = 3'((int'(ptr) + k) % NUM_UNITS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_wb.sv
// Writeback arbiter: grants one finished execution unit per cycle into a single output slot.
// Define EXE_WB_RR_EN for round-robin priority; otherwise fixed priority ALU>MEM>CSR>FPU>DIV>FDIV.
module exe_wb_arb
  import exe_wb_arb_pkg::*;
(
  input  logic         clk,
  input  logic         reset_,
  input  logic         flush,
  exe_wb_arb_if.slave  bus
);

  logic [NUM_UNITS-1:0] req, pick_req, gnt;
  logic                 slot_free, any_gnt;
  ExeUnit_t             gnt_idx;

  logic                 wb_e_q;
  ExeUnit_t             wb_unit_q;
  logic [ROB_ID_W-1:0]  wb_tag_q;
  logic [DATA_W-1:0]    wb_data_q;
  logic                 wb_exp_q;

  assign req = ~{bus.done_mem_, bus.done_csr_, bus.done_fdiv_,
                 bus.done_fpu_, bus.done_div_, bus.done_alu_};

  // A stalled full slot must keep its value, so grants only happen when it can be overwritten.
  assign slot_free = wb_e_q | ~bus.wb_stall;
  assign pick_req  = (slot_free && !flush && reset_) ? req : '0;

`ifdef EXE_WB_RR_EN
  ExeUnit_t ptr;

  exe_wb_rr u_pick (
    .req (pick_req),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)
      ptr <= UNIT_ALU;
    else if (any_gnt)
      ptr <= next_unit(gnt_idx);
  end
`else
  logic [NUM_UNITS-1:0] perm_req, perm_gnt;

  // Reorder requests into priority order so the picker with a fixed zero pointer yields fixed priority.
  always_comb begin
    perm_req = '0;
    gnt      = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      perm_req[3'(i)]       = pick_req[FIXED_ORDER[i]];
      gnt[FIXED_ORDER[i]]   = perm_gnt[3'(i)];
    end
  end

  exe_wb_rr u_pick (
    .req (perm_req),
    .ptr (UNIT_ALU),
    .gnt (perm_gnt)
  );
`endif

  assign any_gnt = |gnt;

  always_comb begin
    gnt_idx = UNIT_ALU;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (gnt[3'(i)])
        gnt_idx = ExeUnit_t'(3'(i));
    end
  end

  assign {bus.gnt_mem_, bus.gnt_csr_, bus.gnt_fdiv_,
          bus.gnt_fpu_, bus.gnt_div_, bus.gnt_alu_} = ~gnt;

  // Payload is only reloaded on a grant, so it holds its last value while wb_e_ is disabled.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wb_e_q    <= 1'b1;
      wb_unit_q <= UNIT_ALU;
      wb_tag_q  <= '0;
      wb_data_q <= '0;
      wb_exp_q  <= 1'b0;
    end else if (flush) begin
      wb_e_q <= 1'b1;
    end else if (any_gnt) begin
      wb_e_q    <= 1'b0;
      wb_unit_q <= gnt_idx;
      wb_tag_q  <= bus.done_tag[gnt_idx];
      wb_data_q <= bus.done_data[gnt_idx];
      wb_exp_q  <= bus.done_exp[gnt_idx];
    end else if (slot_free) begin
      wb_e_q <= 1'b1;
    end
  end

  assign bus.wb_e_   = wb_e_q;
  assign bus.wb_unit = wb_unit_q;
  assign bus.wb_tag  = wb_tag_q;
  assign bus.wb_data = wb_data_q;
  assign bus.wb_exp  = wb_exp_q;

endmodule

// File: tb/tb_exe_wb_arb.sv
// Directed self-checking bench for exe_wb_arb; expectations follow EXE_WB_RR_EN when it is defined.
module tb_exe_wb_arb;
  import exe_wb_arb_pkg::*;

  logic clk = 1'b0;
  logic reset_;
  logic flush;
  logic [NUM_UNITS-1:0] req_mask;
  int checks = 0;
  int errors = 0;

  exe_wb_arb_if bus();

  exe_wb_arb dut (
    .clk    (clk),
    .reset_ (reset_),
    .flush  (flush),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] gnt_vec();
    return {bus.gnt_mem_, bus.gnt_csr_, bus.gnt_fdiv_,
            bus.gnt_fpu_, bus.gnt_div_, bus.gnt_alu_};
  endfunction

  function automatic logic [5:0] one_gnt(input ExeUnit_t u);
    logic [5:0] v;
    v    = 6'h3F;
    v[u] = 1'b0;
    return v;
  endfunction

  task drive();
    {bus.done_mem_, bus.done_csr_, bus.done_fdiv_,
     bus.done_fpu_, bus.done_div_, bus.done_alu_} = ~req_mask;
  endtask

  task check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task check_gnt(input string tag, input logic [5:0] expv);
    #1;
    check(tag, 64'(gnt_vec()), 64'(expv));
  endtask

  task check_wb(input string tag, input logic e, input ExeUnit_t u,
                input logic [ROB_ID_W-1:0] t, input logic [DATA_W-1:0] d, input logic x);
    check({tag, ".wb_e_"},   64'(bus.wb_e_),   64'(e));
    check({tag, ".wb_unit"}, 64'(bus.wb_unit), 64'(u));
    check({tag, ".wb_tag"},  64'(bus.wb_tag),  64'(t));
    check({tag, ".wb_data"}, 64'(bus.wb_data), 64'(d));
    check({tag, ".wb_exp"},  64'(bus.wb_exp),  64'(x));
  endtask

  // Advance one clock; units that were granted drop their request after the edge.
  task step();
    logic [5:0] g;
    g = ~gnt_vec();
    @(posedge clk);
    #1;
    req_mask = req_mask & ~g;
    drive();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_       = 1'b0;
    flush        = 1'b0;
    bus.wb_stall = 1'b0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.done_tag[u]  = ROB_ID_W'(10 + u);
      bus.done_data[u] = DATA_W'(32'hA000 + u);
      bus.done_exp[u]  = 1'b0;
    end
    req_mask = 6'b000001;
    drive();

    // Reset: outputs cleared, grants suppressed even with a request present.
    repeat (2) @(posedge clk);
    #1;
    check_wb("reset", 1'b1, UNIT_ALU, '0, '0, 1'b0);
    check_gnt("reset.gnt", 6'h3F);
    req_mask = '0;
    drive();
    reset_ = 1'b1;
    step();

    // Single ALU result: granted same cycle, visible one cycle later, then drains.
    bus.done_tag[UNIT_ALU]  = 6'd5;
    bus.done_data[UNIT_ALU] = 32'h1234;
    req_mask = 6'b000001;
    drive();
    check_gnt("alu.gnt", one_gnt(UNIT_ALU));
    step();
    check_wb("alu.wb", 1'b0, UNIT_ALU, 6'd5, 32'h1234, 1'b0);
    check_gnt("alu.idle", 6'h3F);
    step();
    check("alu.drain", 64'(bus.wb_e_), 64'(1'b1));
    check("alu.hold_tag", 64'(bus.wb_tag), 64'(6'd5));

    // Mid-stream reset after an FPU result lands.
    req_mask = 6'b000100;
    drive();
    check_gnt("fpu.gnt", one_gnt(UNIT_FPU));
    step();
    check("fpu.wb_e_", 64'(bus.wb_e_), 64'(1'b0));
    reset_ = 1'b0;
    #1;
    check_wb("midreset", 1'b1, UNIT_ALU, '0, '0, 1'b0);
    @(posedge clk);
    #1;
    reset_ = 1'b1;

    // All six pending: one grant per cycle in arbitration order.
    req_mask = 6'h3F;
    drive();
`ifdef EXE_WB_RR_EN
    check_gnt("all.0", one_gnt(UNIT_ALU));  step();
    check_gnt("all.1", one_gnt(UNIT_DIV));  step();
    check_gnt("all.2", one_gnt(UNIT_FPU));  step();
    check_gnt("all.3", one_gnt(UNIT_FDIV)); step();
    check_gnt("all.4", one_gnt(UNIT_CSR));  step();
    check_gnt("all.5", one_gnt(UNIT_MEM));  step();
    check_wb("all.last", 1'b0, UNIT_MEM, 6'd15, 32'hA005, 1'b0);
`else
    check_gnt("all.0", one_gnt(UNIT_ALU));  step();
    check_gnt("all.1", one_gnt(UNIT_MEM));  step();
    check_gnt("all.2", one_gnt(UNIT_CSR));  step();
    check_gnt("all.3", one_gnt(UNIT_FPU));  step();
    check_gnt("all.4", one_gnt(UNIT_DIV));  step();
    check_gnt("all.5", one_gnt(UNIT_FDIV)); step();
    check_wb("all.last", 1'b0, UNIT_FDIV, 6'd13, 32'hA003, 1'b0);
`endif

    // ALU re-requesting every cycle alongside FDIV.
    req_mask = 6'b001001;
    drive();
    check_gnt("starve.0", one_gnt(UNIT_ALU));
    step();
    req_mask = req_mask | 6'b000001;
    drive();
`ifdef EXE_WB_RR_EN
    check_gnt("starve.1", one_gnt(UNIT_FDIV));
`else
    check_gnt("starve.1", one_gnt(UNIT_ALU));
`endif
    step();
    req_mask = '0;
    drive();
    step();

    // Back-pressure: full slot with stall blocks DIV for three cycles.
    bus.done_tag[UNIT_CSR]  = 6'd20;
    bus.done_data[UNIT_CSR] = 32'hC5C5;
    bus.done_tag[UNIT_DIV]  = 6'd21;
    bus.done_data[UNIT_DIV] = 32'hD1D1;
    req_mask = 6'b010000;
    drive();
    check_gnt("csr.gnt", one_gnt(UNIT_CSR));
    step();
    bus.wb_stall = 1'b1;
    req_mask = 6'b000010;
    drive();
    check_gnt("stall.gnt0", 6'h3F);
    for (int c = 0; c < 3; c++) begin
      step();
      check_wb("stall.wb", 1'b0, UNIT_CSR, 6'd20, 32'hC5C5, 1'b0);
      check_gnt("stall.gnt", 6'h3F);
    end
    bus.wb_stall = 1'b0;
    check_gnt("unstall.gnt", one_gnt(UNIT_DIV));
    step();
    check_wb("div.wb", 1'b0, UNIT_DIV, 6'd21, 32'hD1D1, 1'b0);

    // Flush with a full slot and MEM pending.
    bus.done_tag[UNIT_MEM]  = 6'd42;
    bus.done_data[UNIT_MEM] = 32'hBEEF0042;
    bus.done_exp[UNIT_MEM]  = 1'b1;
    flush    = 1'b1;
    req_mask = 6'b100000;
    drive();
    check_gnt("flush.gnt", 6'h3F);
    step();
    flush = 1'b0;
    check("flush.wb_e_", 64'(bus.wb_e_), 64'(1'b1));
    check_gnt("postflush.gnt", one_gnt(UNIT_MEM));
    step();
    check_wb("mem.wb", 1'b0, UNIT_MEM, 6'd42, 32'hBEEF0042, 1'b1);
    step();
    check("final.drain", 64'(bus.wb_e_), 64'(1'b1));
    check("final.hold_data", 64'(bus.wb_data), 64'(32'hBEEF0042));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
